// File: rtl/hazard_sb_pkg.sv
// Shared pipeline opcode definitions and hazard-unit encodings.
// The load decode lives here so the forwarding unit can reuse it.
package hazard_sb_pkg;

    // Opcode field: bits [HBIT_OPC:0] of the instruction word.
    localparam int HBIT_OPC = 5;
    localparam int OPC_W    = HBIT_OPC + 1;

    // Opcodes referenced by the hazard and forwarding logic.
    localparam logic [OPC_W-1:0] OPC_NOP      = 6'h00;
    localparam logic [OPC_W-1:0] OPC_RU_ADD   = 6'h01;
    localparam logic [OPC_W-1:0] OPC_RU_SUB   = 6'h02;
    localparam logic [OPC_W-1:0] OPC_RU_LDu   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_RU_STu   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_SR_SRLDu = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SR_SRSTu = 6'h24;

    // Hazard unit operating modes.
    localparam int HAZ_MODE_SB     = 0;  // per-register scoreboard
    localparam int HAZ_MODE_GLOBAL = 1;  // legacy global stall on any load

    // True when the ID/EX slot holds a real load (register or special-register).
    function automatic logic is_load(input logic valid, input logic [OPC_W-1:0] opc);
        return valid && ((opc == OPC_RU_LDu) || (opc == OPC_SR_SRLDu));
    endfunction

endpackage

// File: rtl/hazard_sb_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline is the master
// (drives ID/EX and IF/ID fields), the hazard unit is the slave.
interface hazard_sb_if
    import hazard_sb_pkg::*;
#(
    parameter int P_NREG = 16
);
    localparam int IW = (P_NREG > 1) ? $clog2(P_NREG) : 1;

    logic                iw_idex_valid;
    logic [OPC_W-1:0]    iw_idex_opc;
    logic [IW-1:0]       iw_idex_tgt;
    logic                iw_ifid_use_a;
    logic                iw_ifid_use_b;
    logic [IW-1:0]       iw_ifid_src_a;
    logic [IW-1:0]       iw_ifid_src_b;
    logic                ow_stall;
    logic [P_NREG-1:0]   ow_pending;

    modport master (
        output iw_idex_valid, iw_idex_opc, iw_idex_tgt,
        output iw_ifid_use_a, iw_ifid_use_b, iw_ifid_src_a, iw_ifid_src_b,
        input  ow_stall, ow_pending
    );

    modport slave (
        input  iw_idex_valid, iw_idex_opc, iw_idex_tgt,
        input  iw_ifid_use_a, iw_ifid_use_b, iw_ifid_src_a, iw_ifid_src_b,
        output ow_stall, ow_pending
    );

endinterface

// File: rtl/hazard_sb_cnt.sv
// Load-use countdown: loads a start value, counts down once per cycle and
// holds at zero. A reload in the same cycle as a decrement wins.
module hazard_cnt #(
    parameter int P_W = 2
) (
    input  logic           iw_clk,
    input  logic           iw_rst,
    input  logic           iw_ld,
    input  logic [P_W-1:0] iw_ld_val,
    output logic [P_W-1:0] ow_cnt
);

    logic [P_W-1:0] cnt_q;

    // Reset overrides reload, reload overrides decrement, zero never wraps.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            cnt_q <= '0;
        end else if (iw_ld) begin
            cnt_q <= iw_ld_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - P_W'(1);
        end
    end

    assign ow_cnt = cnt_q;

endmodule

// File: rtl/hazard_sb.sv
// Load-use hazard unit. Mode HAZ_MODE_SB keeps a countdown per architectural
// register and stalls only readers of a pending load target. Mode
// HAZ_MODE_GLOBAL reproduces the legacy fixed stall after any load.
module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int P_NREG = 16,
    parameter int P_LAT  = 3,
    parameter int P_MODE = HAZ_MODE_SB
) (
    input  logic       iw_clk,
    input  logic       iw_rst,
    hazard_sb_if.slave hz
);

    localparam int IW = (P_NREG > 1) ? $clog2(P_NREG) : 1;
    localparam int CW = $clog2(P_LAT + 1);
    localparam logic [CW-1:0] LAT_V = CW'(P_LAT);

    // Indices at or above P_NREG (possible when P_NREG is not a power of two)
    // address no register and must neither load nor stall.
    function automatic logic idx_ok(input logic [IW-1:0] idx);
        return int'(idx) < P_NREG;
    endfunction

    logic              load_det;
    logic              stall;
    logic [P_NREG-1:0] pend;

    assign load_det      = is_load(hz.iw_idex_valid, hz.iw_idex_opc);
    assign hz.ow_stall   = stall;
    assign hz.ow_pending = pend;

    if (P_MODE == HAZ_MODE_SB) begin : g_sb

        logic [CW-1:0]     cnt [P_NREG];
        logic [P_NREG-1:0] ld_r;
        logic              tgt_ok;

        assign tgt_ok = idx_ok(hz.iw_idex_tgt);

        for (genvar r = 0; r < P_NREG; r++) begin : g_reg
            assign ld_r[r] = load_det && tgt_ok && (hz.iw_idex_tgt == IW'(r));
            assign pend[r] = (cnt[r] != '0);

            hazard_cnt #(
                .P_W (CW)
            ) u_cnt (
                .iw_clk    (iw_clk),
                .iw_rst    (iw_rst),
                .iw_ld     (ld_r[r]),
                .iw_ld_val (LAT_V),
                .ow_cnt    (cnt[r])
            );
        end

        // Stall only when an enabled IF/ID source names a register still counting down.
        always_comb begin
            stall = 1'b0;
            if (hz.iw_ifid_use_a && idx_ok(hz.iw_ifid_src_a) &&
                (cnt[hz.iw_ifid_src_a] != '0)) begin
                stall = 1'b1;
            end
            if (hz.iw_ifid_use_b && idx_ok(hz.iw_ifid_src_b) &&
                (cnt[hz.iw_ifid_src_b] != '0)) begin
                stall = 1'b1;
            end
        end

    end else begin : g_global

        logic [CW-1:0] gcnt;
        logic          g_ld;
        logic          unused_ifid;

        // Loads seen while the window is open are dropped, not restarted.
        assign g_ld = load_det && (gcnt == '0);

        hazard_cnt #(
            .P_W (CW)
        ) u_cnt (
            .iw_clk    (iw_clk),
            .iw_rst    (iw_rst),
            .iw_ld     (g_ld),
            .iw_ld_val (LAT_V),
            .ow_cnt    (gcnt)
        );

        assign stall = (gcnt != '0);
        assign pend  = {P_NREG{stall}};

        // The legacy unit stalls regardless of register numbers.
        assign unused_ifid = ^{hz.iw_idex_tgt, hz.iw_ifid_use_a, hz.iw_ifid_use_b,
                               hz.iw_ifid_src_a, hz.iw_ifid_src_b};

    end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: scoreboard mode (16 and 12 registers)
// and legacy global-stall mode, driven side by side.
module tb_hazard_sb;
    import hazard_sb_pkg::*;

    logic iw_clk = 1'b0;
    logic iw_rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 iw_clk = ~iw_clk;

    hazard_sb_if #(.P_NREG(16)) b0 ();
    hazard_sb_if #(.P_NREG(16)) b1 ();
    hazard_sb_if #(.P_NREG(12)) b2 ();

    hazard_sb #(.P_NREG(16), .P_LAT(3), .P_MODE(HAZ_MODE_SB)) u0 (
        .iw_clk (iw_clk), .iw_rst (iw_rst), .hz (b0));
    hazard_sb #(.P_NREG(16), .P_LAT(3), .P_MODE(HAZ_MODE_GLOBAL)) u1 (
        .iw_clk (iw_clk), .iw_rst (iw_rst), .hz (b1));
    hazard_sb #(.P_NREG(12), .P_LAT(3), .P_MODE(HAZ_MODE_SB)) u2 (
        .iw_clk (iw_clk), .iw_rst (iw_rst), .hz (b2));

    task automatic tick;
        @(posedge iw_clk);
        @(negedge iw_clk);
    endtask

    task automatic clear_inputs;
        b0.iw_idex_valid = 1'b0; b0.iw_idex_opc = '0; b0.iw_idex_tgt = '0;
        b0.iw_ifid_use_a = 1'b0; b0.iw_ifid_use_b = 1'b0;
        b0.iw_ifid_src_a = '0;   b0.iw_ifid_src_b = '0;
        b1.iw_idex_valid = 1'b0; b1.iw_idex_opc = '0; b1.iw_idex_tgt = '0;
        b1.iw_ifid_use_a = 1'b0; b1.iw_ifid_use_b = 1'b0;
        b1.iw_ifid_src_a = '0;   b1.iw_ifid_src_b = '0;
        b2.iw_idex_valid = 1'b0; b2.iw_idex_opc = '0; b2.iw_idex_tgt = '0;
        b2.iw_ifid_use_a = 1'b0; b2.iw_ifid_use_b = 1'b0;
        b2.iw_ifid_src_a = '0;   b2.iw_ifid_src_b = '0;
    endtask

    task automatic test_reset;
        iw_rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_tests++; if (b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL reset_sb_stall: got %b want 0", b0.ow_stall); end
        n_tests++; if (b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL reset_sb_pending: got %h want 0000", b0.ow_pending); end
        n_tests++; if (b1.ow_stall !== 1'b0) begin n_fail++; $display("FAIL reset_gl_stall: got %b want 0", b1.ow_stall); end
        n_tests++; if (b1.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL reset_gl_pending: got %h want 0000", b1.ow_pending); end
        n_tests++; if (b2.ow_pending !== 12'h000) begin n_fail++; $display("FAIL reset_n12_pending: got %h want 000", b2.ow_pending); end
        // load presented while reset is held must be overridden
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd1;
        tick();
        n_tests++; if (b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL reset_load_override: got %h want 0000", b0.ow_pending); end
        clear_inputs();
        iw_rst = 1'b0;
        tick();
        n_tests++; if (b0.ow_stall !== 1'b0 || b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL idle_zero: got stall=%b pend=%h want 0/0000", b0.ow_stall, b0.ow_pending); end
    endtask

    task automatic test_load_use;
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd5;
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd5;
        #1;
        n_tests++; if (b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL lu_prelaunch: got %b want 0", b0.ow_stall); end
        tick();
        b0.iw_idex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (b0.ow_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall[%0d]: got %b want 1", i, b0.ow_stall); end
            n_tests++; if (b0.ow_pending !== 16'h0020) begin n_fail++; $display("FAIL lu_pending[%0d]: got %h want 0020", i, b0.ow_pending); end
            tick();
        end
        #1;
        n_tests++; if (b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", b0.ow_stall); end
        n_tests++; if (b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL lu_pending_clear: got %h want 0000", b0.ow_pending); end
    endtask

    task automatic test_no_reader;
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd5;
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd6;
        tick();
        b0.iw_idex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL nr_stall[%0d]: got %b want 0", i, b0.ow_stall); end
            n_tests++; if (b0.ow_pending !== ((i < 3) ? 16'h0020 : 16'h0000)) begin n_fail++; $display("FAIL nr_pending[%0d]: got %h want %h", i, b0.ow_pending, (i < 3) ? 16'h0020 : 16'h0000); end
            tick();
        end
    endtask

    task automatic test_non_load;
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_ADD; b0.iw_idex_tgt = 4'd5;
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd5;
        tick();
        n_tests++; if (b0.ow_pending !== 16'h0000 || b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL nl_alu: got pend=%h stall=%b want 0000/0", b0.ow_pending, b0.ow_stall); end
        b0.iw_idex_valid = 1'b0; b0.iw_idex_opc = OPC_RU_LDu;
        tick();
        n_tests++; if (b0.ow_pending !== 16'h0000 || b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL nl_bubble: got pend=%h stall=%b want 0000/0", b0.ow_pending, b0.ow_stall); end
        // special-register load, read through source B only
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_SR_SRLDu; b0.iw_idex_tgt = 4'd9;
        b0.iw_ifid_use_a = 1'b0; b0.iw_ifid_src_a = 4'd9;
        b0.iw_ifid_use_b = 1'b1; b0.iw_ifid_src_b = 4'd9;
        tick();
        b0.iw_idex_valid = 1'b0;
        #1;
        n_tests++; if (b0.ow_pending !== 16'h0200) begin n_fail++; $display("FAIL srld_pending: got %h want 0200", b0.ow_pending); end
        n_tests++; if (b0.ow_stall !== 1'b1) begin n_fail++; $display("FAIL srld_use_b: got %b want 1", b0.ow_stall); end
        b0.iw_ifid_use_b = 1'b0;
        #1;
        n_tests++; if (b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL srld_use_a_off: got %b want 0", b0.ow_stall); end
        tick(); tick(); tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] pexp [5];
        logic        s2 [5];
        logic        s3 [5];
        pexp = '{16'h0004, 16'h000C, 16'h000C, 16'h0008, 16'h0000};
        s2   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s3   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd2;
        tick();
        b0.iw_idex_tgt = 4'd3;
        b0.iw_ifid_use_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b0.iw_ifid_src_a = 4'd2;
            #1;
            n_tests++; if (b0.ow_pending !== pexp[i]) begin n_fail++; $display("FAIL b2b_pending[%0d]: got %h want %h", i, b0.ow_pending, pexp[i]); end
            n_tests++; if (b0.ow_stall !== s2[i]) begin n_fail++; $display("FAIL b2b_rd_r2[%0d]: got %b want %b", i, b0.ow_stall, s2[i]); end
            b0.iw_ifid_src_a = 4'd3;
            #1;
            n_tests++; if (b0.ow_stall !== s3[i]) begin n_fail++; $display("FAIL b2b_rd_r3[%0d]: got %b want %b", i, b0.ow_stall, s3[i]); end
            tick();
            b0.iw_idex_valid = 1'b0;
        end
    endtask

    task automatic test_reload;
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd4;
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd4;
        tick();
        b0.iw_idex_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            n_tests++; if (b0.ow_stall !== ((i < 6) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL reload_stall[%0d]: got %b want %b", i, b0.ow_stall, (i < 6) ? 1'b1 : 1'b0); end
            // second load lands while the counter sits at 1
            b0.iw_idex_valid = (i == 2);
            tick();
        end
        n_tests++; if (b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL reload_drain: got %h want 0000", b0.ow_pending); end
    endtask

    task automatic test_global;
        logic gexp [5];
        gexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_inputs();
        b1.iw_idex_valid = 1'b1; b1.iw_idex_opc = OPC_RU_LDu; b1.iw_idex_tgt = 4'd5;
        #1;
        n_tests++; if (b1.ow_stall !== 1'b0) begin n_fail++; $display("FAIL gl_prelaunch: got %b want 0", b1.ow_stall); end
        tick();
        for (int i = 0; i < 5; i++) begin
            b1.iw_ifid_use_a = (i == 1); b1.iw_ifid_src_a = 4'd9;
            #1;
            n_tests++; if (b1.ow_stall !== gexp[i]) begin n_fail++; $display("FAIL gl_trace[%0d]: got %b want %b", i, b1.ow_stall, gexp[i]); end
            n_tests++; if (b1.ow_pending !== (gexp[i] ? 16'hFFFF : 16'h0000)) begin n_fail++; $display("FAIL gl_pending[%0d]: got %h want %h", i, b1.ow_pending, gexp[i] ? 16'hFFFF : 16'h0000); end
            tick();
            b1.iw_idex_valid = 1'b0;
        end
        // once idle, a fresh load opens a new window
        b1.iw_idex_valid = 1'b1; b1.iw_idex_opc = OPC_SR_SRLDu;
        tick();
        b1.iw_idex_valid = 1'b0;
        n_tests++; if (b1.ow_stall !== 1'b1) begin n_fail++; $display("FAIL gl_restart: got %b want 1", b1.ow_stall); end
        tick(); tick(); tick();
        n_tests++; if (b1.ow_stall !== 1'b0) begin n_fail++; $display("FAIL gl_restart_end: got %b want 0", b1.ow_stall); end
    endtask

    task automatic test_reset_mid_stall;
        clear_inputs();
        b0.iw_idex_valid = 1'b1; b0.iw_idex_opc = OPC_RU_LDu; b0.iw_idex_tgt = 4'd5;
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd5;
        tick();
        b0.iw_idex_valid = 1'b0;
        tick();
        n_tests++; if (b0.ow_stall !== 1'b1) begin n_fail++; $display("FAIL rms_in_stall: got %b want 1", b0.ow_stall); end
        iw_rst = 1'b1;
        b0.iw_idex_valid = 1'b1; b0.iw_idex_tgt = 4'd7;
        b1.iw_idex_valid = 1'b1; b1.iw_idex_opc = OPC_RU_LDu;
        tick();
        n_tests++; if (b0.ow_stall !== 1'b0 || b0.ow_pending !== 16'h0000) begin n_fail++; $display("FAIL rms_abort: got stall=%b pend=%h want 0/0000", b0.ow_stall, b0.ow_pending); end
        n_tests++; if (b1.ow_stall !== 1'b0) begin n_fail++; $display("FAIL rms_gl_abort: got %b want 0", b1.ow_stall); end
        iw_rst = 1'b0;
        clear_inputs();
        b0.iw_ifid_use_a = 1'b1; b0.iw_ifid_src_a = 4'd7;
        tick();
        n_tests++; if (b0.ow_pending !== 16'h0000 || b0.ow_stall !== 1'b0) begin n_fail++; $display("FAIL rms_clean: got pend=%h stall=%b want 0000/0", b0.ow_pending, b0.ow_stall); end
        n_tests++; if (b1.ow_stall !== 1'b0) begin n_fail++; $display("FAIL rms_gl_clean: got %b want 0", b1.ow_stall); end
    endtask

    task automatic test_out_of_range;
        clear_inputs();
        b2.iw_idex_valid = 1'b1; b2.iw_idex_opc = OPC_RU_LDu; b2.iw_idex_tgt = 4'd13;
        b2.iw_ifid_use_a = 1'b1; b2.iw_ifid_src_a = 4'd13;
        tick();
        n_tests++; if (b2.ow_pending !== 12'h000 || b2.ow_stall !== 1'b0) begin n_fail++; $display("FAIL oor_tgt: got pend=%h stall=%b want 000/0", b2.ow_pending, b2.ow_stall); end
        b2.iw_idex_tgt = 4'd11;
        tick();
        b2.iw_idex_valid = 1'b0;
        #1;
        n_tests++; if (b2.ow_pending !== 12'h800) begin n_fail++; $display("FAIL oor_top_reg: got %h want 800", b2.ow_pending); end
        n_tests++; if (b2.ow_stall !== 1'b0) begin n_fail++; $display("FAIL oor_src: got %b want 0", b2.ow_stall); end
        b2.iw_ifid_src_a = 4'd11;
        #1;
        n_tests++; if (b2.ow_stall !== 1'b1) begin n_fail++; $display("FAIL oor_top_read: got %b want 1", b2.ow_stall); end
        tick(); tick(); tick();
        n_tests++; if (b2.ow_pending !== 12'h000) begin n_fail++; $display("FAIL oor_drain: got %h want 000", b2.ow_pending); end
    endtask

    initial begin
        iw_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_reader();
        test_non_load();
        test_back_to_back();
        test_reload();
        test_global();
        test_reset_mid_stall();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
